// File: rtl/btn_debounce_reader.sv
// Push-button front end: 2-FF synchroniser, per-channel debounce, press/release
// strobes and, when BTN_REPEAT_EN is defined, hold-to-auto-repeat strobes.
// Without BTN_REPEAT_EN no hold logic is built and btn_repeat is tied to 0.
module btn_debounce_reader #(
    parameter int unsigned N_BTN            = 3,
    parameter bit          ACTIVE_LOW       = 1'b1,
    parameter int unsigned DEBOUNCE_CYC     = 270000,
    parameter int unsigned REPEAT_DELAY_CYC = 13500000,
    parameter int unsigned REPEAT_RATE_CYC  = 2700000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [N_BTN-1:0] PIN_IDLE = {N_BTN{ACTIVE_LOW}};

    // Elaboration-time parameter sanity
    if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYC must be at least 2");
    end
    if (REPEAT_DELAY_CYC < 2 || REPEAT_RATE_CYC < 2) begin : g_bad_repeat
        $error("REPEAT_DELAY_CYC and REPEAT_RATE_CYC must be at least 2");
    end

    logic [N_BTN-1:0] s0_q;
    logic [N_BTN-1:0] s1_q;
    logic [N_BTN-1:0] sample;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic [N_BTN-1:0] level_q;
    logic [N_BTN-1:0] level_d;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] press_d;
    logic [N_BTN-1:0] release_q;
    logic [N_BTN-1:0] release_d;

    // Normalise polarity so sample=1 always means pressed
    assign sample = ACTIVE_LOW ? ~s1_q : s1_q;

    // Debounce: accept a new level on the DEBOUNCE_CYC-th consecutive differing sample
    always_comb begin
        level_d   = level_q;
        cnt_d     = cnt_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            if (sample[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i]   = sample[i];
                cnt_d[i]     = '0;
                press_d[i]   = sample[i];
                release_d[i] = ~sample[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Synchroniser and debounce registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_q      <= PIN_IDLE;
            s1_q      <= PIN_IDLE;
            cnt_q     <= '{default: '0};
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            s0_q      <= btn_raw;
            s1_q      <= s0_q;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef BTN_REPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                       REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int unsigned HOLD_W = $clog2(HOLD_MAX);
    localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE_CYC - 1);

    localparam logic [1:0] HS_IDLE  = 2'd0;
    localparam logic [1:0] HS_DELAY = 2'd1;
    localparam logic [1:0] HS_RATE  = 2'd2;

    logic [1:0]        hs_q [N_BTN];
    logic [1:0]        hs_d [N_BTN];
    logic [HOLD_W-1:0] hc_q [N_BTN];
    logic [HOLD_W-1:0] hc_d [N_BTN];
    logic [N_BTN-1:0]  repeat_q;
    logic [N_BTN-1:0]  repeat_d;

    // Hold FSM next state: arm on press, first repeat after delay, then at rate
    always_comb begin
        hs_d     = hs_q;
        hc_d     = hc_q;
        repeat_d = '0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            if (!level_d[i]) begin
                hs_d[i] = HS_IDLE;
                hc_d[i] = '0;
            end else begin
                case (hs_q[i])
                    HS_IDLE: begin
                        if (press_d[i]) begin
                            hs_d[i] = HS_DELAY;
                            hc_d[i] = '0;
                        end
                    end
                    HS_DELAY: begin
                        if (hc_q[i] == DELAY_LAST) begin
                            repeat_d[i] = 1'b1;
                            hs_d[i]     = HS_RATE;
                            hc_d[i]     = '0;
                        end else begin
                            hc_d[i] = hc_q[i] + HOLD_W'(1);
                        end
                    end
                    HS_RATE: begin
                        if (hc_q[i] == RATE_LAST) begin
                            repeat_d[i] = 1'b1;
                            hc_d[i]     = '0;
                        end else begin
                            hc_d[i] = hc_q[i] + HOLD_W'(1);
                        end
                    end
                    default: begin
                        hs_d[i] = HS_IDLE;
                        hc_d[i] = '0;
                    end
                endcase
            end
        end
    end

    // Hold FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_q     <= '{default: HS_IDLE};
            hc_q     <= '{default: '0};
            repeat_q <= '0;
        end else begin
            hs_q     <= hs_d;
            hc_q     <= hc_d;
            repeat_q <= repeat_d;
        end
    end

    assign btn_repeat = repeat_q;
`else
    assign btn_repeat = '0;
`endif

endmodule
